// File: rtl/picosoc_bus_pkg.sv
// Shared encodings for the two-master PicoRV32 native-bus arbiter.
// FSM state, master indices and the default watchdog error word.
package picosoc_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// Per-transaction stall watchdog: counts BUSY cycles without s_ready, flags expiry.
// expire is combinational from the count, so it lands in the cycle it is detected.
module picosoc_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic busy,
    input  logic s_ready,
    output logic expire
);

    localparam bit              ENABLED = TIMEOUT_CYCLES > 0;
    localparam int              CW      = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   LIMIT   = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0]   SAT     = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Held at zero while idle, so the first BUSY cycle always starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!busy) begin
            count <= '0;
        end else if (!s_ready && count != SAT) begin
            count <= count + 1'b1;
        end
    end

    assign expire = ENABLED && busy && !s_ready && (count == LIMIT);

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native memory port between two masters.
// One idle cycle to arbitrate, grant locked per transaction; stalled slaves are cut off by the watchdog.
module picosoc_bus_arbiter
    import picosoc_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_irq
);

    state_t state;
    logic   owner;
    logic   rr_last;
    logic   busy;
    logic   own_valid;
    logic   pick;
    logic   expire;
    logic   done_ok;
    logic   done_to;
    logic   own_ready;
    logic [31:0] resp_rdata;

    assign busy       = (state == BUSY);
    assign own_valid  = (owner == M1) ? m1_valid : m0_valid;
    // On a tie the master that was not served last wins.
    assign pick       = (m0_valid && m1_valid) ? ~rr_last : (m1_valid ? M1 : M0);
    assign done_ok    = busy && own_valid && s_ready;
    assign done_to    = busy && own_valid && expire;
    assign own_ready  = done_ok || done_to;
    assign resp_rdata = expire ? TIMEOUT_RDATA : s_rdata;

    picosoc_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .busy    (busy),
        .s_ready (s_ready),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= M0;
            rr_last <= M1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= BUSY;
                        owner <= pick;
                    end
                end
                BUSY: begin
                    // A master abandoning its request is not a completion: keep rr_last.
                    if (!own_valid) begin
                        state <= IDLE;
                    end else if (s_ready || expire) begin
                        state   <= IDLE;
                        rr_last <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        grant       = 2'b00;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        timeout_irq = done_to;
        if (busy) begin
            s_valid = own_valid && !expire;
            if (owner == M1) begin
                grant    = 2'b10;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = own_ready;
                m1_rdata = resp_rdata;
            end else begin
                grant    = 2'b01;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = own_ready;
                m0_rdata = resp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Self-checking bench for picosoc_bus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference of the arbitration rules.
module tb_picosoc_bus_arbiter;

    localparam int          TO      = 8;
    localparam logic [31:0] TO_WORD = 32'hDEAD_BEEF;

    logic        clk;
    logic        resetn;
    logic [1:0]  mv;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_irq;

    int n_tests, n_fail;
    int serving, age, last;
    int lat, slv_cnt, sv_cnt, irq_cnt;
    int req_pct [2];
    bit rnd, rd_fix;
    logic [31:0] rd_val, cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          done_q [$];
    logic [31:0] done_rd [$];

    picosoc_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_RDATA  (TO_WORD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (mv[0]),
        .m0_ready    (m0_ready),
        .m0_addr     (ma[0]),
        .m0_wdata    (mw[0]),
        .m0_wstrb    (ms[0]),
        .m0_rdata    (m0_rdata),
        .m1_valid    (mv[1]),
        .m1_ready    (m1_ready),
        .m1_addr     (ma[1]),
        .m1_wdata    (mw[1]),
        .m1_wstrb    (ms[1]),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .timeout_irq (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick_lat();
        if ($urandom_range(3) == 0) return int'($urandom_range(10, 6));
        return int'($urandom_range(3));
    endfunction

    task automatic post(input int x, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mv[x] = 1'b1;
        ma[x] = a;
        mw[x] = d;
        ms[x] = s;
    endtask

    task automatic clear_log();
        sv_cnt  = 0;
        irq_cnt = 0;
        done_q.delete();
        done_rd.delete();
    endtask

    // Holds reset across one rising edge; pending requests are presented at release.
    task automatic hold_reset(input logic [1:0] pend);
        resetn  = 1'b0;
        mv      = pend;
        s_ready = 1'b0;
        slv_cnt = 0;
        serving = -1;
        age     = 0;
        last    = 1;
        @(posedge clk);
        #4;
        resetn = 1'b1;
    endtask

    task automatic apply_reset(input logic [1:0] pend);
        #2;
        hold_reset(pend);
    endtask

    // One clock: check outputs at the falling edge, advance the reference, then drive agents.
    task automatic cycle();
        logic [1:0]  rdy;
        logic [31:0] rd [2];
        logic        to;
        @(negedge clk);
        rdy   = {m1_ready, m0_ready};
        rd[0] = m0_rdata;
        rd[1] = m1_rdata;
        to    = 1'b0;
        if (serving < 0) begin
            chk("idle_grant", 32'(grant), 32'(0));
            chk("idle_s_valid", 32'(s_valid), 32'(0));
            chk("idle_ready", 32'(rdy), 32'(0));
            chk("idle_irq", 32'(timeout_irq), 32'(0));
            chk("idle_s_addr", s_addr, 32'(0));
            chk("idle_m0_rdata", rd[0], 32'(0));
            chk("idle_m1_rdata", rd[1], 32'(0));
        end else if (mv[serving]) begin
            to = (age == TO - 1) && !s_ready;
            chk("grant", 32'(grant), 32'(serving == 0 ? 1 : 2));
            chk("s_valid", 32'(s_valid), 32'(!to));
            chk("ready", 32'(rdy), 32'((s_ready || to) ? (serving == 0 ? 1 : 2) : 0));
            chk("irq", 32'(timeout_irq), 32'(to));
            chk("s_addr", s_addr, ma[serving]);
            chk("s_wdata", s_wdata, mw[serving]);
            chk("s_wstrb", 32'(s_wstrb), 32'(ms[serving]));
            if (s_ready || to) chk("owner_rdata", rd[serving], to ? TO_WORD : s_rdata);
            chk("other_rdata", rd[1 - serving], 32'(0));
        end else begin
            chk("drop_grant", 32'(grant), 32'(serving == 0 ? 1 : 2));
            chk("drop_ready", 32'(rdy), 32'(0));
            chk("drop_s_valid", 32'(s_valid), 32'(0));
            chk("drop_irq", 32'(timeout_irq), 32'(0));
        end

        if (s_valid) begin
            sv_cnt++;
            slv_cnt++;
            cap_addr  = s_addr;
            cap_wdata = s_wdata;
            cap_wstrb = s_wstrb;
        end else begin
            slv_cnt = 0;
        end
        if (timeout_irq) irq_cnt++;
        if (m0_ready) begin
            done_q.push_back(0);
            done_rd.push_back(m0_rdata);
        end
        if (m1_ready) begin
            done_q.push_back(1);
            done_rd.push_back(m1_rdata);
        end
        if ((m0_ready || m1_ready) && rnd) lat = pick_lat();

        if (serving < 0) begin
            if (mv[0] && mv[1]) serving = 1 - last;
            else if (mv[0]) serving = 0;
            else if (mv[1]) serving = 1;
            age = 0;
        end else if (!mv[serving]) begin
            serving = -1;
        end else if (s_ready || to) begin
            last    = serving;
            serving = -1;
        end else begin
            age++;
        end

        @(posedge clk);
        #1;
        for (int x = 0; x < 2; x++) begin
            if (rdy[x]) mv[x] = 1'b0;
            if (!mv[x] && int'($urandom_range(99)) < req_pct[x]) begin
                mv[x] = 1'b1;
                ma[x] = $urandom;
                mw[x] = $urandom;
                ms[x] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            end
        end
        s_ready = (slv_cnt == lat);
        s_rdata = rd_fix ? rd_val : $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
        mv = 2'b00;
        for (int x = 0; x < 2; x++) begin
            ma[x] = '0;
            mw[x] = '0;
            ms[x] = '0;
            req_pct[x] = 0;
        end
        s_ready = 1'b0;
        s_rdata = '0;
        n_tests = 0;
        n_fail = 0;
        serving = -1;
        age = 0;
        last = 1;
        lat = 1;
        slv_cnt = 0;
        rnd = 1'b0;
        rd_fix = 1'b1;
        rd_val = '0;
        cap_addr = '0;
        cap_wdata = '0;
        cap_wstrb = '0;
        clear_log();

        #3;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_s_valid", 32'(s_valid), 32'(0));
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'(0));
        chk("rst_irq", 32'(timeout_irq), 32'(0));
        @(posedge clk);
        #4;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single m0 read with a two-cycle slave.
        rd_val = 32'h1234_5678;
        lat = 2;
        post(0, 32'h0000_0010, 32'h0, 4'h0);
        cycle();
        chk("t1_grant", 32'(grant), 32'(1));
        repeat (6) cycle();
        chk("t1_count", 32'(done_q.size()), 32'(1));
        chk("t1_master", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(0));
        chk("t1_rdata", done_rd.size() > 0 ? done_rd[0] : 32'h0, 32'h1234_5678);
        chk("t1_m1_ready", 32'(done_q.sum()), 32'(0));

        // Simultaneous requests out of reset, then both held continuously.
        clear_log();
        lat = 1;
        post(0, 32'h0000_0100, 32'h0, 4'h0);
        post(1, 32'h0000_0200, 32'h0, 4'h0);
        apply_reset(2'b11);
        repeat (8) cycle();
        chk("t2_count", 32'(done_q.size()), 32'(2));
        chk("t2_first", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(0));
        chk("t2_second", 32'(done_q.size() > 1 ? done_q[1] : -1), 32'(1));
        clear_log();
        req_pct[0] = 100;
        req_pct[1] = 100;
        repeat (20) cycle();
        chk("t2_alt_count_ge4", 32'(done_q.size() >= 4), 32'(1));
        for (int i = 0; i < 4; i++)
            chk("t2_alternation", 32'(done_q.size() > i ? done_q[i] : -1), 32'(i % 2));
        req_pct[0] = 0;
        req_pct[1] = 0;
        repeat (8) cycle();

        // m1 byte write reaches the slave port unaltered.
        clear_log();
        lat = 2;
        post(1, 32'h0200_0008, 32'h0000_0041, 4'b0001);
        repeat (6) cycle();
        chk("t3_s_addr", cap_addr, 32'h0200_0008);
        chk("t3_s_wdata", cap_wdata, 32'h0000_0041);
        chk("t3_s_wstrb", 32'(cap_wstrb), 32'(4'b0001));
        chk("t3_valid_cycles", 32'(sv_cnt), 32'(3));
        chk("t3_master", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(1));

        // Slave never answers: watchdog completes the access.
        clear_log();
        lat = 99;
        post(0, 32'h0000_0040, 32'h0, 4'h0);
        repeat (12) cycle();
        chk("t4_valid_cycles", 32'(sv_cnt), 32'(TO - 1));
        chk("t4_irq_pulses", 32'(irq_cnt), 32'(1));
        chk("t4_count", 32'(done_q.size()), 32'(1));
        chk("t4_rdata", done_rd.size() > 0 ? done_rd[0] : 32'h0, TO_WORD);
        chk("t4_idle_grant", 32'(grant), 32'(0));

        // Slave answers in exactly the last allowed cycle.
        clear_log();
        lat = 7;
        rd_val = 32'hCAFE_0005;
        post(0, 32'h0000_0044, 32'h0, 4'h0);
        repeat (12) cycle();
        chk("t5_irq_pulses", 32'(irq_cnt), 32'(0));
        chk("t5_valid_cycles", 32'(sv_cnt), 32'(TO));
        chk("t5_rdata", done_rd.size() > 0 ? done_rd[0] : 32'h0, 32'hCAFE_0005);

        // Asynchronous reset in the middle of a transaction.
        lat = 99;
        post(0, 32'h0000_0080, 32'h0, 4'h0);
        cycle();
        s_ready = 1'b1;
        #1;
        chk("t6_pre_ready", 32'(m0_ready), 32'(1));
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'(0));
        chk("t6_async_s_valid", 32'(s_valid), 32'(0));
        chk("t6_async_ready", 32'({m1_ready, m0_ready}), 32'(0));
        ma[1] = 32'h0000_0300;
        mw[1] = 32'h0;
        ms[1] = 4'h0;
        lat = 1;
        hold_reset(2'b10);
        cycle();
        chk("t6_m1_grant", 32'(grant), 32'(2));
        repeat (4) cycle();
        post(0, 32'h0000_0400, 32'h0, 4'h0);
        repeat (5) cycle();
        post(0, 32'h0000_0500, 32'h0, 4'h0);
        post(1, 32'h0000_0600, 32'h0, 4'h0);
        apply_reset(2'b11);
        cycle();
        chk("t6_pair_grant", 32'(grant), 32'(1));
        repeat (6) cycle();

        // Owner abandons its request: no completion and round-robin history unchanged.
        post(0, 32'h0000_0700, 32'h0, 4'h0);
        repeat (4) cycle();
        lat = 99;
        post(1, 32'h0000_0800, 32'h0, 4'h0);
        repeat (3) cycle();
        mv[1] = 1'b0;
        clear_log();
        repeat (2) cycle();
        chk("t8_no_ready", 32'(done_q.size()), 32'(0));
        post(0, 32'h0000_0900, 32'h0, 4'h0);
        post(1, 32'h0000_0A00, 32'h0, 4'h0);
        cycle();
        chk("t8_grant", 32'(grant), 32'(2));
        lat = 1;
        repeat (8) cycle();

        // Random traffic with random slave latency, including timeouts.
        rnd = 1'b1;
        rd_fix = 1'b0;
        lat = pick_lat();
        for (int k = 0; k < 4; k++) begin
            req_pct[0] = int'($urandom_range(90, 10));
            req_pct[1] = int'($urandom_range(90, 10));
            repeat (500) cycle();
        end
        req_pct[0] = 0;
        req_pct[1] = 0;
        repeat (30) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
